// File: rtl/seq_pkg.sv
// Shared types for the program sequencer: branch condition codes, FSM states, ALU flag bundle.
package seq_pkg;

    localparam int unsigned COND_W = 3;

    typedef enum logic [COND_W-1:0] {
        COND_ALW  = 3'd0,
        COND_Z    = 3'd1,
        COND_NZ   = 3'd2,
        COND_PAR  = 3'd3,
        COND_SCO  = 3'd4,
        COND_RSV5 = 3'd5,
        COND_RSV6 = 3'd6,
        COND_RSV7 = 3'd7
    } cond_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic par;
        logic sco;
    } flags_t;

    // Reserved condition codes are never taken.
    function automatic logic cond_true(input cond_t c, input flags_t f);
        logic taken;
        taken = 1'b0;
        case (c)
            COND_ALW: taken = 1'b1;
            COND_Z:   taken = f.zero;
            COND_NZ:  taken = ~f.zero;
            COND_PAR: taken = f.par;
            COND_SCO: taken = f.sco;
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address stack: LIFO of PC values with full/empty status.
// Push on full and pop on empty are ignored; the caller turns them into a fault.
module ret_stack #(
    parameter int unsigned PC_W      = 6,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [PC_W-1:0] i_data,
    output logic [PC_W-1:0] o_top_c,
    output logic            o_full_c,
    output logic            o_empty_c
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0]  r_mem [RAS_DEPTH];
    logic [CNT_W-1:0] r_ptr;
    logic [CNT_W-1:0] w_top_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full_c  = (r_ptr == CNT_W'(RAS_DEPTH));
    assign o_empty_c = (r_ptr == '0);
    assign w_do_push = i_push && !o_full_c;
    assign w_do_pop  = i_pop && !o_empty_c;
    assign w_top_idx = r_ptr - CNT_W'(1);
    assign o_top_c   = r_mem[IDX_W'(w_top_idx)];

    // Occupancy pointer; push takes priority if both are ever requested.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_do_push) begin
            r_ptr <= r_ptr + CNT_W'(1);
        end else if (w_do_pop) begin
            r_ptr <= w_top_idx;
        end
    end

    // Entry storage needs no reset: only slots below r_ptr are ever read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[IDX_W'(r_ptr)] <= i_data;
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Fetch-side control: PC, programmable jump table, latched ALU flags and return-address stack,
// with a RUN/HALTED/FAULT state machine.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned PC_W      = 6,
    parameter int unsigned JPTR_W    = 2,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Halt,
    input  logic              Jen,
    input  logic [COND_W-1:0] Cond,
    input  logic [JPTR_W-1:0] Jptr,
    input  logic              Call,
    input  logic              Ret,
    input  logic              FlagWen,
    input  logic              Zero,
    input  logic              Par,
    input  logic              SCo,
    input  logic              LutWen,
    input  logic [JPTR_W-1:0] LutAddr,
    input  logic [PC_W-1:0]   LutDat,
    output logic [PC_W-1:0]   PC,
    output logic              Done,
    output logic              Fault
);

    localparam int unsigned LUT_DEPTH = 2 ** JPTR_W;

    logic [PC_W-1:0] r_lut [LUT_DEPTH];

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    flags_t          r_flags;
    flags_t          w_flags_nxt;
    logic            r_done;
    logic            r_fault;
    logic            w_done_nxt;
    logic            w_fault_nxt;

    logic            w_push;
    logic            w_pop;
    logic [PC_W-1:0] w_ras_top;
    logic            w_ras_full;
    logic            w_ras_empty;

    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_cond_ok;

    // Target read uses the pre-write table contents (read-before-write).
    assign w_target  = r_lut[Jptr];
    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_cond_ok = cond_true(cond_t'(Cond), r_flags);

    ret_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ret_stack (
        .i_clk     (Clk),
        .i_rst_n   (Reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (w_pc_inc),
        .o_top_c   (w_ras_top),
        .o_full_c  (w_ras_full),
        .o_empty_c (w_ras_empty)
    );

    // Next-state / next-PC: Halt > Stall > Ret > Call > taken branch > PC+1.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flags_nxt = r_flags;
        w_push      = 1'b0;
        w_pop       = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (FlagWen && !Stall) begin
                    w_flags_nxt = {Zero, Par, SCo};
                end
                if (Halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (!Stall) begin
                    if (Ret) begin
                        if (w_ras_empty) begin
                            w_state_nxt = ST_FAULT;
                        end else begin
                            w_pop    = 1'b1;
                            w_pc_nxt = w_ras_top;
                        end
                    end else if (Call) begin
                        if (w_ras_full) begin
                            w_state_nxt = ST_FAULT;
                        end else begin
                            w_push   = 1'b1;
                            w_pc_nxt = w_target;
                        end
                    end else if (Jen && w_cond_ok) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase

        w_done_nxt  = (w_state_nxt == ST_HALTED);
        w_fault_nxt = (w_state_nxt == ST_FAULT);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
            r_flags <= '0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_flags <= w_flags_nxt;
            r_done  <= w_done_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // Jump table writes proceed regardless of stall.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < int'(LUT_DEPTH); i++) begin
                r_lut[i] <= '0;
            end
        end else if (LutWen) begin
            r_lut[LutAddr] <= LutDat;
        end
    end

    assign PC    = r_pc;
    assign Done  = r_done;
    assign Fault = r_fault;

endmodule
